// File: rtl/audio_fifo_pwm.sv
// Show-ahead stereo sample FIFO feeding a pair of 8-bit PWM channels.
// The FIFO and the PWM share the clock and reset but are otherwise independent.
module audio_fifo_pwm #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     aclr_n,
  input  logic [WIDTH-1:0]         data,
  input  logic                     wrreq,
  input  logic                     rdreq,
  output logic [WIDTH-1:0]         q,
  output logic                     rdempty,
  output logic                     wrfull,
  output logic [$clog2(DEPTH):0]   usedw,
  input  logic [7:0]               left_top,
  input  logic [7:0]               right_top,
  output logic                     left,
  output logic                     right
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   USED_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   USED_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_usedw;
  logic             r_empty;
  logic             r_full;

  logic             w_do_wr;
  logic             w_do_rd;
  logic [AW:0]      w_usedw_nxt;

  // A full FIFO still accepts a write when the same edge pops, so the count holds.
  assign w_do_rd = rdreq & ~r_empty;
  assign w_do_wr = wrreq & (~r_full | rdreq);

  always_comb begin
    w_usedw_nxt = r_usedw;
    case ({w_do_wr, w_do_rd})
      2'b10:   w_usedw_nxt = r_usedw + USED_ONE;
      2'b01:   w_usedw_nxt = r_usedw - USED_ONE;
      default: w_usedw_nxt = r_usedw;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usedw  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_usedw <= w_usedw_nxt;
      r_empty <= (w_usedw_nxt == '0);
      r_full  <= (w_usedw_nxt == USED_FULL);
    end
  end

  // NOTE: storage has no reset; stale words are never visible because q is gated by r_empty.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= data;
  end

  assign q       = r_empty ? '0 : r_mem[r_rd_ptr];
  assign rdempty = r_empty;
  assign wrfull  = r_full;
  assign usedw   = r_usedw;

  logic [7:0] r_cnt;
  logic [7:0] r_dl;
  logic [7:0] r_dr;
  logic       r_left;
  logic       r_right;

  // Duties are latched only at the period boundary so a period is never split.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_cnt   <= '0;
      r_dl    <= '0;
      r_dr    <= '0;
      r_left  <= 1'b0;
      r_right <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + 8'd1;
      r_left  <= (r_cnt < r_dl);
      r_right <= (r_cnt < r_dr);
      if (r_cnt == 8'hFF) begin
        r_dl <= left_top;
        r_dr <= right_top;
      end
    end
  end

  assign left  = r_left;
  assign right = r_right;

endmodule

// File: tb/tb_audio_fifo_pwm.sv
// Bench for audio_fifo_pwm: directed scenarios plus random traffic against a
// queue-based FIFO model and a period/duty arithmetic PWM model.
module tb_audio_fifo_pwm;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  logic              clk;
  logic              aclr_n;
  logic [WIDTH-1:0]  data;
  logic              wrreq;
  logic              rdreq;
  logic [WIDTH-1:0]  q;
  logic              rdempty;
  logic              wrfull;
  logic [4:0]        usedw;
  logic [7:0]        left_top;
  logic [7:0]        right_top;
  logic              left;
  logic              right;

  audio_fifo_pwm #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .data      (data),
    .wrreq     (wrreq),
    .rdreq     (rdreq),
    .q         (q),
    .rdempty   (rdempty),
    .wrfull    (wrfull),
    .usedw     (usedw),
    .left_top  (left_top),
    .right_top (right_top),
    .left      (left),
    .right     (right)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] m_fifo [$];
  int               m_edges;
  int               m_dl;
  int               m_dr;
  logic             m_left;
  logic             m_right;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_edges = 0;
    m_dl    = 0;
    m_dr    = 0;
    m_left  = 1'b0;
    m_right = 1'b0;
  endtask

  task automatic check_all(input string pfx);
    logic [WIDTH-1:0] exp_q;
    exp_q = (m_fifo.size() == 0) ? '0 : m_fifo[0];
    check({pfx, ".q"},       32'(q),       32'(exp_q));
    check({pfx, ".rdempty"}, 32'(rdempty), 32'(m_fifo.size() == 0));
    check({pfx, ".wrfull"},  32'(wrfull),  32'(m_fifo.size() == DEPTH));
    check({pfx, ".usedw"},   32'(usedw),   32'(m_fifo.size()));
    check({pfx, ".left"},    32'(left),    32'(m_left));
    check({pfx, ".right"},   32'(right),   32'(m_right));
  endtask

  // One clock edge: update the model from the inputs held across the edge, then compare.
  task automatic step();
    bit pop;
    bit push;
    int phase;
    @(posedge clk);
    pop  = rdreq && (m_fifo.size() != 0);
    push = wrreq && ((m_fifo.size() != DEPTH) || rdreq);
    if (pop)  void'(m_fifo.pop_front());
    if (push) m_fifo.push_back(data);
    phase   = m_edges % 256;
    m_left  = (phase < m_dl);
    m_right = (phase < m_dr);
    if (phase == 255) begin
      m_dl = int'(left_top);
      m_dr = int'(right_top);
    end
    m_edges++;
    #1;
    check_all("step");
  endtask

  task automatic count_high(input int n, output int lh, output int rh);
    lh = 0;
    rh = 0;
    for (int k = 0; k < n; k++) begin
      step();
      lh += int'(left);
      rh += int'(right);
    end
  endtask

  task automatic drain();
    rdreq = 1'b1;
    wrreq = 1'b0;
    for (int k = 0; k < 2 * DEPTH && m_fifo.size() != 0; k++) step();
    rdreq = 1'b0;
    check("drain_empty", 32'(rdempty), 32'd1);
  endtask

  initial begin
    int lh;
    int rh;
    logic [WIDTH-1:0] last;

    aclr_n    = 1'b0;
    data      = '0;
    wrreq     = 1'b0;
    rdreq     = 1'b0;
    left_top  = '0;
    right_top = '0;
    model_reset();
    #23;
    check_all("reset");
    @(negedge clk);
    aclr_n = 1'b1;

    // Fill to 16, drop a 17th write, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      wrreq = 1'b1;
      data  = WIDTH'(i + 1);
      step();
    end
    check("fill.wrfull", 32'(wrfull), 32'd1);
    check("fill.usedw",  32'(usedw),  32'd16);
    data = 16'hFFFF;
    step();
    wrreq = 1'b0;
    check("overflow.usedw", 32'(usedw), 32'd16);
    rdreq = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("pop_order", 32'(q), 32'(i + 1));
      step();
    end
    rdreq = 1'b0;
    check("drained.rdempty", 32'(rdempty), 32'd1);
    check("drained.q",       32'(q),       32'd0);

    // Pop on empty, then simultaneous write+pop on empty.
    rdreq = 1'b1;
    step();
    wrreq = 1'b1;
    data  = 16'h1234;
    step();
    wrreq = 1'b0;
    rdreq = 1'b0;
    check("empty_wr_rd.usedw", 32'(usedw), 32'd1);
    check("empty_wr_rd.q",     32'(q),     32'h1234);
    drain();

    // Simultaneous write+pop on a full FIFO.
    wrreq = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      data = WIDTH'($urandom);
      step();
    end
    rdreq = 1'b1;
    data  = 16'hABCD;
    step();
    wrreq = 1'b0;
    rdreq = 1'b0;
    check("full_wr_rd.usedw", 32'(usedw), 32'd16);
    rdreq = 1'b1;
    last  = '0;
    for (int k = 0; k < 2 * DEPTH && !rdempty; k++) begin
      last = q;
      step();
    end
    rdreq = 1'b0;
    check("full_wr_rd.last", 32'(last), 32'hABCD);

    // PWM duties 0x40 / 0xC0, then 0 on left.
    left_top  = 8'h40;
    right_top = 8'hC0;
    for (int k = 0; k < 512; k++) step();
    count_high(256, lh, rh);
    check("pwm40.left_high",  32'(lh), 32'd64);
    check("pwmC0.right_high", 32'(rh), 32'd192);
    left_top = 8'h00;
    for (int k = 0; k < 512; k++) step();
    count_high(256, lh, rh);
    check("pwm0.left_high", 32'(lh), 32'd0);

    // Mid-period duty change takes effect only at the next period.
    left_top = 8'h40;
    for (int k = 0; k < 512; k++) step();
    for (int k = 0; k < 256 && (m_edges % 256) != 32; k++) step();
    left_top = 8'h10;
    count_high(224, lh, rh);
    check("midchange.old_period", 32'(lh), 32'd32);
    count_high(256, lh, rh);
    check("midchange.new_period", 32'(lh), 32'd16);

    // Random traffic with write-heavy, balanced and read-heavy phases.
    for (int ph = 0; ph < 3; ph++) begin
      for (int k = 0; k < 200; k++) begin
        wrreq = ($urandom_range(0, 99) < (75 - 25 * ph));
        rdreq = ($urandom_range(0, 99) < (25 + 25 * ph));
        data  = WIDTH'($urandom);
        if ($urandom_range(0, 63) == 0) begin
          left_top  = 8'($urandom);
          right_top = 8'($urandom);
        end
        step();
      end
    end
    wrreq = 1'b0;
    rdreq = 1'b0;

    // Asynchronous reset with 5 words stored and PWM active.
    drain();
    left_top  = 8'h80;
    right_top = 8'h30;
    for (int k = 0; k < 300; k++) step();
    wrreq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data = WIDTH'(16'h0A00 + i);
      step();
    end
    wrreq = 1'b0;
    check("prereset.usedw", 32'(usedw), 32'd5);
    for (int k = 0; k < 300 && !left; k++) step();
    check("prereset.left", 32'(left), 32'd1);
    #2;
    aclr_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    aclr_n = 1'b1;
    step();
    check("postreset.usedw", 32'(usedw), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_fifo_pwm.md
AUDIO_FIFO_PWM -- requirements
Module: audio_fifo_pwm

Interface
REQ-001 Parameter WIDTH, default 16: FIFO word width in bits; each word carries {right[7:0], left[7:0]}.
REQ-002 Parameter DEPTH, default 16: FIFO capacity in words; SHALL be a power of two.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 aclr_n  input  1  reset, asynchronous and active-low.
REQ-005 data  input  WIDTH  FIFO write data.
REQ-006 wrreq  input  1  FIFO write request, sampled on the rising edge of clk.
REQ-007 rdreq  input  1  FIFO read (pop) request, sampled on the rising edge of clk.
REQ-008 q  output  WIDTH  show-ahead head word; 0 when empty.
REQ-009 rdempty  output  1  high when the FIFO holds 0 words.
REQ-010 wrfull  output  1  high when the FIFO holds DEPTH words.
REQ-011 usedw  output  log2(DEPTH)+1  current word count, range 0..DEPTH.
REQ-012 left_top  input  8  left PWM duty (high count per 256-cycle period).
REQ-013 right_top  input  8  right PWM duty.
REQ-014 left  output  1  left PWM output.
REQ-015 right  output  1  right PWM output.

Function
REQ-016 FIFO SHALL be first-in first-out with registered read and write pointers of log2(DEPTH) bits that wrap DEPTH-1 -> 0.
REQ-017 A write SHALL occur on a rising edge with wrreq=1 and wrfull=0; when wrfull=1, wrreq SHALL be ignored (no data or pointer change).
REQ-018 A pop SHALL occur on a rising edge with rdreq=1 and rdempty=0; when rdempty=1, rdreq SHALL be ignored.
REQ-019 When wrreq=1 and rdreq=1 on the same edge while full, both SHALL occur and usedw SHALL stay DEPTH.
REQ-020 When wrreq=1 and rdreq=1 on the same edge while empty, only the write SHALL occur (usedw 0 -> 1).
REQ-021 When neither full nor empty, simultaneous write and pop SHALL both occur and leave usedw unchanged.
REQ-022 q SHALL present the oldest stored word combinationally from the storage and read pointer, with no read latency; after a pop, q SHALL show the next word in the cycle following the edge.
REQ-023 A word written into an empty FIFO SHALL appear on q, with rdempty=0, in the cycle following the write edge.
REQ-024 rdempty, wrfull and usedw SHALL be derived from registered state and SHALL be glitch-free.
REQ-025 The PWM SHALL use a free-running 8-bit counter cnt that increments every clk cycle and wraps 255 -> 0, giving a period of 256 cycles.
REQ-026 The active duties dl and dr SHALL be loaded from left_top and right_top on the edge where cnt wraps 255 -> 0; changes in the duty inputs mid-period SHALL take effect only at the next period.
REQ-027 left SHALL be registered as (cnt < dl) and right as (cnt < dr); a duty of 0 SHALL give a constant low output, and a duty of N SHALL give exactly N high cycles per period.
REQ-028 left and right SHALL be registered outputs with one cycle of latency relative to cnt.

Reset
REQ-029 While aclr_n=0: pointers, usedw and storage-valid state SHALL be 0; rdempty=1; wrfull=0; q=0; cnt=0; dl=dr=0; left=right=0.
REQ-030 Reset assertion SHALL take effect immediately without a clock edge, and SHALL discard FIFO contents mid-operation.
REQ-031 The first rising edge after aclr_n deasserts SHALL be a normal operating edge; cnt SHALL start at 0 and the first duty load SHALL occur at the first 255 -> 0 wrap.

Verification
REQ-032 Write 0x0001..0x0010 (16 words) -> wrfull=1 and usedw=16; a 17th write of 0xFFFF is dropped; 16 pops return 0x0001..0x0010 in order, then rdempty=1 and q=0.
REQ-033 Pop on an empty FIFO, then wrreq+rdreq together on the empty FIFO with data 0x1234 -> usedw=1 and q=0x1234.
REQ-034 Full FIFO, then wrreq+rdreq with 0xABCD -> usedw stays 16 and 0xABCD is the last word drained.
REQ-035 Duty inputs 0x40/0xC0 held across a period -> left high for 64 and right high for 192 of every 256 cycles; duty 0 -> left constant low.
REQ-036 Change left_top mid-period -> the current period keeps the old duty and the next period uses the new one.
REQ-037 Pull aclr_n low with 5 words stored and PWM active -> outputs immediately reset to the REQ-029 values, and after release usedw=0.
